// File: rtl/dog_window_feeder_pkg.sv
// -----------------------------------------------------------------------------
// dog_pkg
// Shared constants and types for the DoG frame-scan feeder and its address
// generator. Image geometry and the DoG-side pixel width live here so the
// feeder and the DoG unit agree on them.
// Optional feature macro used by the feeder: FEEDER_HOLD_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package dog_pkg;

    localparam int IMG_W  = 256;
    localparam int IMG_H  = 256;
    localparam int WIN    = 5;
    localparam int X_LAST = IMG_W - WIN;   // tag of the row-turn beat (DoGwidth)
    localparam int Y_LAST = IMG_H - WIN;   // Y tag of the final row
    localparam int PIX_W  = 8;

    typedef enum logic {
        RM_VERT = 1'b0,
        RM_HORZ = 1'b1
    } rmode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRIME = 3'd1,
        SCAN  = 3'd2,
        TURN  = 3'd3,
        LAST  = 3'd4
    } fsm_t;

endpackage

// File: rtl/dog_window_feeder_serpentine_addr_gen.sv
// -----------------------------------------------------------------------------
// serpentine_addr_gen
// Maps a scan position to the image RAM read request for that beat.
// Purely combinational.
// Ports:
//   state  in  3  feeder FSM state (dog_pkg::fsm_t encoding)
//   x, y   in  8  X / Y tag of the beat
//   dir    in  1  0 = left-to-right, 1 = right-to-left
//   pcnt   in  3  prime counter; 0 is the settling cycle, 1..5 are prime beats
//   req    out 1  a read is issued for this beat
//   row    out 8  read row address
//   col    out 8  read column address
//   mode   out 1  0 = vertical 5-row read, 1 = horizontal 5-column read
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module serpentine_addr_gen
    import dog_pkg::*;
(
    input  logic [2:0] state,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       dir,
    input  logic [2:0] pcnt,
    output logic       req,
    output logic [7:0] row,
    output logic [7:0] col,
    output logic       mode
);

    logic [8:0] r9;
    logic [8:0] c9;
    logic       unused_carry;

    always_comb begin
        req  = 1'b0;
        mode = RM_VERT;
        r9   = '0;
        c9   = '0;
        case (fsm_t'(state))
            PRIME: begin
                if (pcnt != 3'd0) begin
                    req = 1'b1;
                    c9  = {6'd0, pcnt} - 9'd1;
                end
            end
            SCAN: begin
                req = 1'b1;
                r9  = {1'b0, y};
                // The window's leading column sits WIN ahead of the tag going
                // right; going left it walks down from the column below X_LAST.
                if (dir)
                    c9 = 9'(X_LAST - 1) - {1'b0, x};
                else
                    c9 = {1'b0, x} + 9'(WIN);
            end
            TURN: begin
                req  = 1'b1;
                mode = RM_HORZ;
                r9   = {1'b0, y} + 9'(WIN);
                c9   = dir ? 9'd0 : 9'(X_LAST);
            end
            default: ;
        endcase
    end

    assign row = r9[7:0];
    assign col = c9[7:0];

    // Addresses stay inside the image by construction; the carry bit is spare.
    assign unused_carry = r9[8] ^ c9[8];

endmodule

// File: rtl/dog_window_feeder.sv
// -----------------------------------------------------------------------------
// dog_window_feeder
// Frame-scan source for the DoG unit. On start it walks the image in
// serpentine order, issuing one 5-pixel read per beat and tagging each beat
// with X/Y/Direction for the DoG 5x5 window consumer.
//
//   state | meaning
//   IDLE  | waiting for start; tags hold, no reads
//   PRIME | cycle 0 settles, then 5 vertical reads at cols 0..4 (tag 0,0,0)
//   SCAN  | one vertical read per X along the current row
//   TURN  | horizontal read of the row entering the window, then next row
//   LAST  | final beat's data on data1..5; done pulses, busy low
//
// Ports:
//   clk, rst (async, active-low), start (1-cycle pulse)
//   hold (only with FEEDER_HOLD_EN): freeze scan, no reads
//   busy, done                      : status
//   mem_raddr_r/c, mem_rmode, mem_ren, mem_rdata : image RAM read port
//   Xout, Yout, Directionout        : beat tags to the DoG unit
//   data1..data5                    : mem_rdata bytes 0..4
// Macro FEEDER_HOLD_EN: adds hold and registers the data outputs
// (data follows its tag by 2 cycles instead of 1).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module dog_window_feeder
    import dog_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef FEEDER_HOLD_EN
    input  logic        hold,
`endif
    output logic        busy,
    output logic        done,
    output logic [7:0]  mem_raddr_r,
    output logic [7:0]  mem_raddr_c,
    output logic        mem_rmode,
    output logic        mem_ren,
    input  logic [39:0] mem_rdata,
    output logic [7:0]  Xout,
    output logic [7:0]  Yout,
    output logic        Directionout,
    output logic [7:0]  data1,
    output logic [7:0]  data2,
    output logic [7:0]  data3,
    output logic [7:0]  data4,
    output logic [7:0]  data5
);

    fsm_t        state_q;
    fsm_t        state_d;
    logic [2:0]  pcnt_q;
    logic [2:0]  pcnt_d;
    logic [7:0]  x_d;
    logic [7:0]  y_d;
    logic        dir_d;
    logic        hold_act;
    logic        gen_req;
    logic [7:0]  gen_row;
    logic [7:0]  gen_col;
    logic        gen_mode;
    logic [39:0] data_src;

`ifdef FEEDER_HOLD_EN
    assign hold_act = hold & (state_q != IDLE);
`else
    assign hold_act = 1'b0;
`endif

    // The tag registers double as the scan counters; the request registers
    // are loaded from the same next-state values so tag and read align.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pcnt_q       <= '0;
            Xout         <= '0;
            Yout         <= '0;
            Directionout <= 1'b0;
            mem_ren      <= 1'b0;
            mem_raddr_r  <= '0;
            mem_raddr_c  <= '0;
            mem_rmode    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            Xout         <= x_d;
            Yout         <= y_d;
            Directionout <= dir_d;
            mem_ren      <= gen_req & ~hold_act;
            if (gen_req && !hold_act) begin
                mem_raddr_r <= gen_row;
                mem_raddr_c <= gen_col;
                mem_rmode   <= gen_mode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        x_d     = Xout;
        y_d     = Yout;
        dir_d   = Directionout;
        if (!hold_act) begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = PRIME;
                        pcnt_d  = '0;
                        x_d     = '0;
                        y_d     = '0;
                        dir_d   = 1'b0;
                    end
                end
                PRIME: begin
                    if (pcnt_q == 3'(WIN)) begin
                        state_d = SCAN;
                        x_d     = '0;
                    end else begin
                        pcnt_d = pcnt_q + 3'd1;
                    end
                end
                SCAN: begin
                    if (Xout == 8'(X_LAST - 1)) begin
                        if (Yout == 8'(Y_LAST)) begin
                            state_d = LAST;
                        end else begin
                            state_d = TURN;
                            x_d     = 8'(X_LAST);
                        end
                    end else begin
                        x_d = Xout + 8'd1;
                    end
                end
                TURN: begin
                    state_d = SCAN;
                    x_d     = '0;
                    y_d     = Yout + 8'd1;
                    dir_d   = ~Directionout;
                end
                LAST:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state_q == PRIME) || (state_q == SCAN) || (state_q == TURN);
        done = (state_q == LAST);
    end

    serpentine_addr_gen u_addr_gen (
        .state (state_d),
        .x     (x_d),
        .y     (y_d),
        .dir   (dir_d),
        .pcnt  (pcnt_d),
        .req   (gen_req),
        .row   (gen_row),
        .col   (gen_col),
        .mode  (gen_mode)
    );

`ifdef FEEDER_HOLD_EN
    logic        ren_q;
    logic [39:0] data_q;

    // Capture each returned read once and keep it, so the DoG side sees
    // stable pixels while the scan is held.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ren_q  <= 1'b0;
            data_q <= '0;
        end else begin
            ren_q <= mem_ren;
            if (ren_q)
                data_q <= mem_rdata;
        end
    end

    assign data_src = data_q;
`else
    assign data_src = mem_rdata;
`endif

    assign data1 = data_src[7:0];
    assign data2 = data_src[15:8];
    assign data3 = data_src[23:16];
    assign data4 = data_src[31:24];
    assign data5 = data_src[39:32];

endmodule

// File: tb/tb_dog_window_feeder.sv
`timescale 1ns/1ps
module tb_dog_window_feeder;
    import dog_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, mem_rmode, mem_ren, Directionout;
    logic [7:0]  mem_raddr_r, mem_raddr_c, Xout, Yout;
    logic [7:0]  data1, data2, data3, data4, data5;
    logic [39:0] mem_rdata;
`ifdef FEEDER_HOLD_EN
    logic        hold;
    localparam int LAT      = 2;
    localparam int HOLD_CYC = 3;
`else
    localparam int LAT      = 1;
    localparam int HOLD_CYC = 0;
`endif
    localparam int N_BEATS = 5 + (IMG_H - WIN + 1) * (IMG_W - WIN) + (IMG_H - WIN);

    always #5 clk = ~clk;

    dog_window_feeder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef FEEDER_HOLD_EN
        .hold         (hold),
`endif
        .busy         (busy),
        .done         (done),
        .mem_raddr_r  (mem_raddr_r),
        .mem_raddr_c  (mem_raddr_c),
        .mem_rmode    (mem_rmode),
        .mem_ren      (mem_ren),
        .mem_rdata    (mem_rdata),
        .Xout         (Xout),
        .Yout         (Yout),
        .Directionout (Directionout),
        .data1        (data1),
        .data2        (data2),
        .data3        (data3),
        .data4        (data4),
        .data5        (data5)
    );

    typedef struct {
        int x; int y; int dir; int mode; int r; int c;
    } beat_t;

    typedef struct {
        int idx; int x; int y; int dir; int mode; int r; int c;
    } vec_t;

    int unsigned seed;
    int          pass_cnt = 0;
    int          chk_cnt  = 0;
    beat_t       exp_q[$];
    beat_t       capt[1:600];
    vec_t        vt[11];

    function automatic logic [7:0] pix(int r, int c);
        return 8'(r * 29 + c * 7 + int'(seed));
    endfunction

    // Image RAM: returns five pixels one cycle after the request.
    always @(posedge clk) begin
        if (mem_ren) begin
            for (int k = 0; k < 5; k++)
                mem_rdata[8*k +: 8] <= mem_rmode ? pix(int'(mem_raddr_r), int'(mem_raddr_c) + k)
                                                 : pix(int'(mem_raddr_r) + k, int'(mem_raddr_c));
        end
    end

    function automatic longint pk(beat_t b);
        return longint'(b.x) | (longint'(b.y) << 8) | (longint'(b.dir) << 16) |
               (longint'(b.mode) << 17) | (longint'(b.r) << 18) | (longint'(b.c) << 26);
    endfunction

    function automatic longint exp_data(beat_t b);
        logic [39:0] v;
        for (int k = 0; k < 5; k++)
            v[8*k +: 8] = b.mode != 0 ? pix(b.r, b.c + k) : pix(b.r + k, b.c);
        return longint'(v);
    endfunction

    function automatic beat_t dut_beat();
        beat_t b;
        b = '{int'(Xout), int'(Yout), int'(Directionout), int'(mem_rmode),
              int'(mem_raddr_r), int'(mem_raddr_c)};
        return b;
    endfunction

    task automatic check(string name, longint act, longint req);
        chk_cnt++;
        if (act == req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    task automatic check_reset(string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_ren"}, mem_ren, 0);
        check({tag, "_raddr_r"}, mem_raddr_r, 0);
        check({tag, "_raddr_c"}, mem_raddr_c, 0);
        check({tag, "_rmode"}, mem_rmode, 0);
        check({tag, "_x"}, Xout, 0);
        check({tag, "_y"}, Yout, 0);
        check({tag, "_dir"}, Directionout, 0);
    endtask

    initial begin
        int    d, cyc, beats, n, quiet;
        bit    done_seen, have_d;
        beat_t e, cur;
        beat_t hist[0:2];
        bit    hv[0:2];
        longint dexp;
`ifdef FEEDER_HOLD_EN
        longint frz;
`endif

        seed  = $urandom;
        rst   = 1'b0;
        start = 1'b0;
`ifdef FEEDER_HOLD_EN
        hold  = 1'b0;
`endif

        // Hand-derived beats: {beat number, X, Y, Dir, mode, row, col}
        vt[0]  = '{1,   0,   0, 0, 0, 0, 0};
        vt[1]  = '{2,   0,   0, 0, 0, 0, 1};
        vt[2]  = '{5,   0,   0, 0, 0, 0, 4};
        vt[3]  = '{6,   0,   0, 0, 0, 0, 5};
        vt[4]  = '{7,   1,   0, 0, 0, 0, 6};
        vt[5]  = '{256, 250, 0, 0, 0, 0, 255};
        vt[6]  = '{257, 251, 0, 0, 1, 5, 251};
        vt[7]  = '{258, 0,   1, 1, 0, 1, 250};
        vt[8]  = '{508, 250, 1, 1, 0, 1, 0};
        vt[9]  = '{509, 251, 1, 1, 1, 6, 0};
        vt[10] = '{510, 0,   2, 0, 0, 2, 5};

        // Reference beat sequence straight from the serpentine rules.
        for (int p = 0; p < WIN; p++) exp_q.push_back('{0, 0, 0, 0, 0, p});
        for (int y = 0; y <= IMG_H - WIN; y++) begin
            d = y % 2;
            for (int x = 0; x < X_LAST; x++)
                exp_q.push_back('{x, y, d, 0, y, (d != 0) ? X_LAST - 1 - x : x + WIN});
            if (y < IMG_H - WIN)
                exp_q.push_back('{X_LAST, y, d, 1, y + WIN, (d != 0) ? 0 : X_LAST});
        end

        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b1;
        repeat ($urandom_range(2, 6)) @(negedge clk);

        // ---------------- full frame ----------------
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("no_req_first_cycle", mem_ren, 0);
        cyc = 0; beats = 0; done_seen = 0; have_d = 0; dexp = 0;
        for (int k = 0; k < 3; k++) begin hv[k] = 0; hist[k] = '{0, 0, 0, 0, 0, 0}; end

        while (!done_seen && cyc < 70000) begin
            e = '{0, 0, 0, 0, 0, 0};
            if (mem_ren) begin
                beats++;
                cur = dut_beat();
                if (beats <= 600) capt[beats] = cur;
                if (exp_q.size() == 0) check("extra_beat", beats, N_BEATS);
                else begin
                    e = exp_q.pop_front();
                    check($sformatf("beat%0d", beats), pk(cur), pk(e));
                end
            end
            for (int k = 2; k > 0; k--) begin hist[k] = hist[k-1]; hv[k] = hv[k-1]; end
            hist[0] = e;
            hv[0]   = mem_ren;
            if (hv[LAT]) begin dexp = exp_data(hist[LAT]); have_d = 1; end
            if (have_d) check($sformatf("data_c%0d", cyc), {data5, data4, data3, data2, data1}, dexp);

`ifdef FEEDER_HOLD_EN
            if (cyc == 1000) begin hold = 1'b1; frz = {Xout, Yout, Directionout}; end
            if (cyc >= 1001 && cyc <= 1003) begin
                check("hold_ren", mem_ren, 0);
                check("hold_tags", {Xout, Yout, Directionout}, frz);
            end
            if (cyc == 1003) hold = 1'b0;
`endif
            if (done) begin
                done_seen = 1;
                check("done_cycle", cyc, N_BEATS + 1 + HOLD_CYC);
                check("beat_count", beats, N_BEATS);
                check("busy_at_done", busy, 0);
                check("ren_at_done", mem_ren, 0);
                start = 1'b1;          // start coinciding with done must be ignored
            end else begin
                start = busy && ($urandom_range(0, 499) == 0);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_seen", done_seen, 1);
        check("done_single_pulse", done, 0);
        check("start_at_done_ignored", busy, 0);
        repeat (3) @(negedge clk);
        check("idle_hold_x", Xout, X_LAST - 1);
        check("idle_hold_y", Yout, IMG_H - WIN);
        check("idle_hold_dir", Directionout, (IMG_H - WIN) % 2);
        check("idle_no_ren", mem_ren, 0);

        for (int i = 0; i < 11; i++)
            check($sformatf("vec_beat%0d", vt[i].idx), pk(capt[vt[i].idx]),
                  pk('{vt[i].x, vt[i].y, vt[i].dir, vt[i].mode, vt[i].r, vt[i].c}));

        // ---------------- reset mid-frame ----------------
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = $urandom_range(20, 400);
        repeat (n) @(negedge clk);
        check("busy_mid_frame", busy, 1);
        rst = 1'b0;
        #1;
        check_reset("mid");
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (done || busy || mem_ren) quiet++;
        end
        check("reset_quiet", quiet, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_after_reset", {busy, done, mem_ren}, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
